// File: rtl/dram_ctrl.sv
// dram_ctrl: host-facing front end for a small DRAM array. Turns one host
// request at a time into a single-cycle DRAM command. A free-running timer
// schedules row refreshes, which take priority over host traffic.
//
// Host handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready depends only on registered state, so it is
// stable for the whole cycle. Every accepted request produces exactly one
// single-cycle resp_valid pulse, unless reset intervenes.
module dram_ctrl #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 8,
    parameter int REF_INTERVAL = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_we,
    output logic              mem_refresh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(REF_INTERVAL - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        RCAP    = 3'd3,
        REFRESH = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer;
    logic              ref_pending;
    logic              ref_clr;
    logic [ADDR_W-1:0] ref_row, ref_row_d;

    logic              mem_we_d, mem_refresh_d, resp_valid_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_din_d, resp_rdata_d;

    // A pending refresh blocks host acceptance even while IDLE.
    assign req_ready = (state_q == IDLE) && !ref_pending;

    // Refresh timer: wraps every REF_INTERVAL cycles and raises a refresh request.
    // The interval is long enough that a new request never collides with a pending one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            ref_pending <= 1'b0;
        end else begin
            if (timer == TIMER_LAST) begin
                timer       <= '0;
                ref_pending <= 1'b1;
            end else begin
                timer <= timer + TW'(1);
                if (ref_clr) begin
                    ref_pending <= 1'b0;
                end
            end
        end
    end

    // State register plus all registered DRAM and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ref_row     <= '0;
            mem_we      <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
        end else begin
            state_q     <= state_d;
            ref_row     <= ref_row_d;
            mem_we      <= mem_we_d;
            mem_refresh <= mem_refresh_d;
            mem_addr    <= mem_addr_d;
            mem_din     <= mem_din_d;
            resp_valid  <= resp_valid_d;
            resp_rdata  <= resp_rdata_d;
        end
    end

    // Next-state and next-output logic; registered outputs hold unless changed here.
    always_comb begin
        state_d       = state_q;
        ref_row_d     = ref_row;
        ref_clr       = 1'b0;
        mem_we_d      = mem_we;
        mem_refresh_d = mem_refresh;
        mem_addr_d    = mem_addr;
        mem_din_d     = mem_din;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata;
        case (state_q)
            IDLE: begin
                if (ref_pending) begin
                    // Refresh wins over a host request in the same cycle.
                    mem_refresh_d = 1'b1;
                    mem_addr_d    = ref_row;
                    ref_clr       = 1'b1;
                    state_d       = REFRESH;
                end else if (req_valid) begin
                    mem_addr_d = req_addr;
                    mem_din_d  = req_wdata;
                    if (req_we) begin
                        mem_we_d = 1'b1;
                        state_d  = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                mem_we_d     = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            READ: begin
                // Address held; the array registers dout on this edge.
                state_d = RCAP;
            end
            RCAP: begin
                resp_rdata_d = mem_dout;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            REFRESH: begin
                mem_refresh_d = 1'b0;
                ref_row_d     = ref_row + ADDR_W'(1);
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: randomized scoreboard bench for dram_ctrl with a behavioural
// DRAM array and a reference memory.
module tb_dram_ctrl;

    localparam int AW     = 3;
    localparam int DW     = 8;
    localparam int RI     = 16;
    localparam int ROWS   = 1 << AW;
    // Edges from the accept edge to the edge that raises resp_valid.
    localparam int WR_LAT = 1;
    localparam int RD_LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          mem_we, mem_refresh;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    dram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .REF_INTERVAL(RI)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_refresh(mem_refresh),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // Behavioural DRAM array: write on we, registered read of addr every edge.
    logic [DW-1:0] dram [ROWS];
    always @(posedge clk) begin
        if (mem_we) dram[mem_addr] <= mem_din;
        mem_dout <= dram[mem_addr];
    end

    // Count of rising edges since reset release.
    int edge_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    bit            exp_rd_q[$];
    int            exp_t_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_din_q[$];
    int            wr_t_q[$];
    logic [DW-1:0] ref_mem [ROWS];
    logic [DW-1:0] last_rd;
    logic [AW-1:0] exp_row;
    int            nref;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, expv, edge_cnt);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [DW-1:0] e;
        bit            rd;
        int            t;
        bit            exp_ready;
        if (rst_n) begin
            chk("we_refresh_exclusive", 32'(mem_we && mem_refresh), 32'd0);
            if (mem_we) begin
                if (wr_t_q.size() == 0) begin
                    chk("unexpected_mem_we", 32'd1, 32'd0);
                end else begin
                    t = wr_t_q.pop_front();
                    chk("mem_we_edge", 32'(edge_cnt), 32'(t));
                    chk("mem_we_addr", 32'(mem_addr), 32'(wr_addr_q.pop_front()));
                    chk("mem_we_din", 32'(mem_din), 32'(wr_din_q.pop_front()));
                end
            end
            if (mem_refresh) begin
                // Refresh j is requested at edge RI*j and must issue within 3 edges.
                chk("refresh_in_window",
                    32'((edge_cnt >= RI * (nref + 1) + 1) && (edge_cnt <= RI * (nref + 1) + 3)), 32'd1);
                chk("refresh_row", 32'(mem_addr), 32'(exp_row));
                nref++;
                exp_row = AW'((int'(exp_row) + 1) % ROWS);
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    rd = exp_rd_q.pop_front();
                    t  = exp_t_q.pop_front();
                    chk("resp_edge", 32'(edge_cnt), 32'(t));
                    if (rd) begin
                        chk("resp_rdata", 32'(resp_rdata), 32'(e));
                        last_rd = e;
                    end else begin
                        chk("rdata_held_on_write", 32'(resp_rdata), 32'(last_rd));
                    end
                end
            end
            // Ready only with no outstanding request, no refresh in flight or owed.
            exp_ready = (exp_q.size() == 0) && (nref >= edge_cnt / RI) && !mem_refresh;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a falling edge.
    task automatic idle(input int n);
        repeat (n) begin
            req_valid = 1'b0;
            req_we    = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
            @(negedge clk); #1;
        end
    endtask

    task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int acc);
        acc       = -1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        for (int i = 0; i < 64 && acc < 0; i++) begin
            if (req_ready) begin
                acc = edge_cnt + 1;
                if (we) begin
                    wr_addr_q.push_back(a);
                    wr_din_q.push_back(d);
                    wr_t_q.push_back(acc);
                    exp_q.push_back(d);
                    exp_rd_q.push_back(1'b0);
                    exp_t_q.push_back(acc + WR_LAT);
                    ref_mem[a] = d;
                end else begin
                    exp_q.push_back(ref_mem[a]);
                    exp_rd_q.push_back(1'b1);
                    exp_t_q.push_back(acc + RD_LAT);
                end
            end
            @(negedge clk); #1;
        end
        req_valid = 1'b0;
        if (acc < 0) chk("req_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input bit now);
        if (!now) begin
            @(negedge clk); #1;
        end
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #2;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_refresh", 32'(mem_refresh), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_din", 32'(mem_din), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        exp_q.delete();
        exp_rd_q.delete();
        exp_t_q.delete();
        wr_addr_q.delete();
        wr_din_q.delete();
        wr_t_q.delete();
        nref    = 0;
        exp_row = '0;
        last_rd = '0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int base;
        int n0;
        for (int i = 0; i < ROWS; i++) begin
            dram[i]    = '0;
            ref_mem[i] = '0;
        end
        mem_dout  = '0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        nref      = 0;
        exp_row   = '0;
        last_rd   = '0;

        do_reset(1'b0);

        // Directed writes and reads.
        do_req(1'b1, 3'd0, 8'hAA, acc);
        do_req(1'b1, 3'd1, 8'h55, acc);
        do_req(1'b0, 3'd0, 8'h00, acc);
        do_req(1'b0, 3'd1, 8'h00, acc);
        idle(2);

        // Refresh request arriving together with a host request.
        base = -1;
        for (int i = 0; i < 3 * RI && base < 0; i++) begin
            if (edge_cnt > 0 && (edge_cnt % RI) == 0 && exp_q.size() == 0) base = edge_cnt;
            else idle(1);
        end
        chk("found_refresh_slot", 32'(base >= 0), 32'd1);
        do_req(1'b1, AW'($urandom), DW'($urandom), acc);
        chk("accept_after_refresh", 32'(acc), 32'(base + 3));

        // Random traffic with random gaps.
        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 4));
            do_req(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), acc);
        end

        // Long idle: full refresh sweep with row wrap, then read everything back.
        idle(4);
        n0 = nref;
        idle(9 * RI);
        chk("sweep_refresh_count", 32'((nref - n0) >= 8 && (nref - n0) <= 10), 32'd1);
        for (int a = 0; a < ROWS; a++) begin
            do_req(1'b0, AW'(a), 8'h00, acc);
        end

        // Reset while a read is in flight: its response must never appear.
        idle(2);
        do_req(1'b0, AW'($urandom), 8'h00, acc);
        do_reset(1'b1);
        idle(10);
        do_req(1'b0, 3'd0, 8'h00, acc);
        do_req(1'b0, 3'd1, 8'h00, acc);
        idle(8);

        chk("refresh_count_final",
            32'(nref >= (edge_cnt - 3) / RI && nref <= edge_cnt / RI), 32'd1);
        chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("write_queue_drained", 32'(wr_t_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
